// File: rtl/modulation_swapchain_pkg.sv
// Shared types and constants for the modulation segment swapchain.
package modulation_swapchain_pkg;

   localparam int          NumSegment  = 2;
   localparam int          IdxWidth    = 15;
   localparam logic [15:0] RepInfinite = 16'hFFFF;

   typedef enum logic [2:0] {
      SYNC_IDX  = 3'd0,
      SYS_TIME  = 3'd1,
      GPIO      = 3'd2,
      IMMEDIATE = 3'd7
   } transition_mode_t;

   typedef enum logic [1:0] {
      INFINITE_LOOP,
      WAIT_START,
      FINITE_LOOP,
      DONE
   } state_t;

endpackage

// File: rtl/modulation_swapchain_transition_trigger.sv
// Single-cycle fire pulse for a pending segment transition, decoded from the latched mode.
module modulation_swapchain_transition_trigger
   import modulation_swapchain_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             armed,
   input  transition_mode_t mode,
   input  logic [63:0]      value,
   input  logic [63:0]      sys_time,
   input  logic [3:0]       gpio_in,
   input  logic             wrap_req,
   output logic             fire
);

   logic [3:0] gpio_prev;
   logic       gpio_rise;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) gpio_prev <= '0;
      else     gpio_prev <= gpio_in;
   end

   assign gpio_rise = gpio_in[value[1:0]] & ~gpio_prev[value[1:0]];

   // NOTE: fire gets a default before the case, so no path leaves it unassigned (no latch).
   always_comb begin
      fire = 1'b0;
      if (armed) begin
         case (mode)
            SYNC_IDX: fire = wrap_req;
            SYS_TIME: fire = (sys_time >= value);
            GPIO:     fire = gpio_rise;
            default:  fire = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/modulation_swapchain.sv
// Segment swapchain for the modulation memory reader: active segment selection,
// triggered transitions and finite repeat playback.
module modulation_swapchain
   // Named imports: a wildcard would let the SYS_TIME port collide with the mode enum member.
   import modulation_swapchain_pkg::NumSegment, modulation_swapchain_pkg::IdxWidth,
          modulation_swapchain_pkg::RepInfinite, modulation_swapchain_pkg::SYNC_IDX,
          modulation_swapchain_pkg::transition_mode_t, modulation_swapchain_pkg::state_t,
          modulation_swapchain_pkg::INFINITE_LOOP, modulation_swapchain_pkg::WAIT_START,
          modulation_swapchain_pkg::FINITE_LOOP, modulation_swapchain_pkg::DONE;
(
   input  logic                CLK,
   input  logic                RST,
   input  logic [63:0]         SYS_TIME,
   input  logic                UPDATE_SETTINGS,
   input  logic                REQ_SEGMENT,
   input  logic [15:0]         REP,
   input  transition_mode_t    TRANSITION_MODE,
   input  logic [63:0]         TRANSITION_VALUE,
   input  logic [3:0]          GPIO_IN,
   input  logic [IdxWidth-1:0] CYCLE  [NumSegment],
   input  logic [IdxWidth-1:0] IDX_IN [NumSegment],
   output logic                SEGMENT,
   output logic [IdxWidth-1:0] IDX,
   output logic                STOP
);

   state_t                state_q, state_d;
   logic                  req_segment_q, req_segment_d;
   logic [15:0]           rep_q, rep_d;
   transition_mode_t      mode_q, mode_d;
   logic [63:0]           value_q, value_d;
   logic [15:0]           loop_cnt_q, loop_cnt_d;
   logic                  segment_d, stop_d;
   logic [IdxWidth-1:0]   idx_d;
   logic [IdxWidth-1:0]   prev_idx_q [NumSegment];
   logic [NumSegment-1:0] wrap;
   logic                  fire;

   always_comb begin
      wrap = '0;
      for (int i = 0; i < NumSegment; i++) wrap[i] = IDX_IN[i] < prev_idx_q[i];
   end

   modulation_swapchain_transition_trigger u_trigger (
      .CLK      (CLK),
      .RST      (RST),
      .armed    (state_q == WAIT_START),
      .mode     (mode_q),
      .value    (value_q),
      .sys_time (SYS_TIME),
      .gpio_in  (GPIO_IN),
      .wrap_req (wrap[req_segment_q]),
      .fire     (fire)
   );

   always_comb begin
      state_d       = state_q;
      req_segment_d = req_segment_q;
      rep_d         = rep_q;
      mode_d        = mode_q;
      value_d       = value_q;
      loop_cnt_d    = loop_cnt_q;
      segment_d     = SEGMENT;
      stop_d        = STOP;
      idx_d         = (state_q == DONE) ? IDX : IDX_IN[SEGMENT];

      // A strobe pre-empts any trigger or final wrap landing in the same cycle.
      if (UPDATE_SETTINGS) begin
         req_segment_d = REQ_SEGMENT;
         rep_d         = REP;
         mode_d        = TRANSITION_MODE;
         value_d       = TRANSITION_VALUE;
         if (REQ_SEGMENT == SEGMENT && REP == RepInfinite) begin
            state_d = INFINITE_LOOP;
            stop_d  = 1'b0;
         end else begin
            state_d = WAIT_START;
         end
      end else begin
         case (state_q)
            WAIT_START: begin
               if (fire) begin
                  segment_d  = req_segment_q;
                  idx_d      = IDX_IN[req_segment_q];
                  stop_d     = 1'b0;
                  loop_cnt_d = '0;
                  state_d    = (rep_q == RepInfinite) ? INFINITE_LOOP : FINITE_LOOP;
               end
            end
            FINITE_LOOP: begin
               if (wrap[SEGMENT]) begin
                  if (loop_cnt_q == rep_q) begin
                     stop_d  = 1'b1;
                     idx_d   = CYCLE[SEGMENT];
                     state_d = DONE;
                  end else begin
                     loop_cnt_d = loop_cnt_q + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= INFINITE_LOOP;
         req_segment_q <= 1'b0;
         rep_q         <= RepInfinite;
         mode_q        <= SYNC_IDX;
         value_q       <= '0;
         loop_cnt_q    <= '0;
         SEGMENT       <= 1'b0;
         IDX           <= '0;
         STOP          <= 1'b0;
         // NOTE: the previous-index array is reset as well, otherwise a stale value could flag a wrap.
         for (int i = 0; i < NumSegment; i++) prev_idx_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         req_segment_q <= req_segment_d;
         rep_q         <= rep_d;
         mode_q        <= mode_d;
         value_q       <= value_d;
         loop_cnt_q    <= loop_cnt_d;
         SEGMENT       <= segment_d;
         IDX           <= idx_d;
         STOP          <= stop_d;
         for (int i = 0; i < NumSegment; i++) prev_idx_q[i] <= IDX_IN[i];
      end
   end

endmodule

// File: tb/tb_modulation_swapchain.sv
// Self-checking bench for modulation_swapchain: directed scenarios plus a random soak,
// all compared against a behavioural playback model.
module tb_modulation_swapchain;
   import modulation_swapchain_pkg::NumSegment;
   import modulation_swapchain_pkg::IdxWidth;
   import modulation_swapchain_pkg::transition_mode_t;

   logic                CLK = 1'b0;
   logic                RST;
   logic [63:0]         SYS_TIME;
   logic                UPDATE_SETTINGS;
   logic                REQ_SEGMENT;
   logic [15:0]         REP;
   transition_mode_t    TRANSITION_MODE;
   logic [63:0]         TRANSITION_VALUE;
   logic [3:0]          GPIO_IN;
   logic [IdxWidth-1:0] CYCLE  [NumSegment];
   logic [IdxWidth-1:0] IDX_IN [NumSegment];
   logic                SEGMENT;
   logic [IdxWidth-1:0] IDX;
   logic                STOP;

   int errors = 0;
   int checks = 0;

   // Playback model: pending request, finite playback with a count of wraps still to play, done.
   logic        m_seg, m_stop, m_waiting, m_finite, m_done;
   logic [14:0] m_idx;
   int          m_wraps_left;
   logic        m_req;
   logic [15:0] m_rep;
   logic [2:0]  m_mode;
   logic [63:0] m_value;
   logic [14:0] m_prev [2];
   logic [3:0]  m_gpio_prev;

   modulation_swapchain dut (
      .CLK              (CLK),
      .RST              (RST),
      .SYS_TIME         (SYS_TIME),
      .UPDATE_SETTINGS  (UPDATE_SETTINGS),
      .REQ_SEGMENT      (REQ_SEGMENT),
      .REP              (REP),
      .TRANSITION_MODE  (TRANSITION_MODE),
      .TRANSITION_VALUE (TRANSITION_VALUE),
      .GPIO_IN          (GPIO_IN),
      .CYCLE            (CYCLE),
      .IDX_IN           (IDX_IN),
      .SEGMENT          (SEGMENT),
      .IDX              (IDX),
      .STOP             (STOP)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_seg = 1'b0; m_idx = '0; m_stop = 1'b0;
      m_waiting = 1'b0; m_finite = 1'b0; m_done = 1'b0; m_wraps_left = 0;
      m_req = 1'b0; m_rep = 16'hFFFF; m_mode = 3'd0; m_value = '0;
      m_prev[0] = '0; m_prev[1] = '0; m_gpio_prev = '0;
   endtask

   // Advances the model across one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [1:0]  wrap;
      logic        rise;
      logic        fire;
      logic [14:0] n_idx;
      for (int i = 0; i < 2; i++) wrap[i] = IDX_IN[i] < m_prev[i];
      rise  = GPIO_IN[m_value[1:0]] && !m_gpio_prev[m_value[1:0]];
      fire  = 1'b0;
      n_idx = m_done ? m_idx : IDX_IN[m_seg];
      if (UPDATE_SETTINGS) begin
         m_req = REQ_SEGMENT; m_rep = REP; m_mode = TRANSITION_MODE; m_value = TRANSITION_VALUE;
         m_done = 1'b0; m_finite = 1'b0;
         if (REQ_SEGMENT == m_seg && REP == 16'hFFFF) begin
            m_waiting = 1'b0; m_stop = 1'b0;
         end else begin
            m_waiting = 1'b1;
         end
      end else if (m_waiting) begin
         case (m_mode)
            3'd0:    fire = wrap[m_req];
            3'd1:    fire = SYS_TIME >= m_value;
            3'd2:    fire = rise;
            default: fire = 1'b1;
         endcase
         if (fire) begin
            m_seg = m_req; n_idx = IDX_IN[m_req]; m_stop = 1'b0; m_waiting = 1'b0;
            m_finite = (m_rep != 16'hFFFF);
            m_wraps_left = int'(m_rep) + 1;
         end
      end else if (m_finite && wrap[m_seg]) begin
         m_wraps_left--;
         if (m_wraps_left == 0) begin
            m_finite = 1'b0; m_done = 1'b1; m_stop = 1'b1; n_idx = CYCLE[m_seg];
         end
      end
      m_idx = n_idx;
      for (int i = 0; i < 2; i++) m_prev[i] = IDX_IN[i];
      m_gpio_prev = GPIO_IN;
   endtask

   task automatic step();
      model_edge();
      @(posedge CLK);
      @(negedge CLK);
      check("segment", 64'(SEGMENT), 64'(m_seg));
      check("idx", 64'(IDX), 64'(m_idx));
      check("stop", 64'(STOP), 64'(m_stop));
      UPDATE_SETTINGS = 1'b0;
      for (int i = 0; i < 2; i++) IDX_IN[i] = (IDX_IN[i] >= CYCLE[i]) ? '0 : IDX_IN[i] + 15'd1;
      SYS_TIME = SYS_TIME + 64'd1;
   endtask

   task automatic strobe(input logic seg, input logic [15:0] rep, input logic [2:0] mode,
                         input logic [63:0] val);
      UPDATE_SETTINGS  = 1'b1;
      REQ_SEGMENT      = seg;
      REP              = rep;
      TRANSITION_MODE  = transition_mode_t'(mode);
      TRANSITION_VALUE = val;
      step();
   endtask

   initial begin
      logic [14:0] v;
      int          n;
      RST = 1'b1; SYS_TIME = '0; UPDATE_SETTINGS = 1'b0; REQ_SEGMENT = 1'b0; REP = '0;
      TRANSITION_MODE = transition_mode_t'(3'd0); TRANSITION_VALUE = '0; GPIO_IN = '0;
      CYCLE[0] = 15'd9; CYCLE[1] = 15'd7; IDX_IN[0] = '0; IDX_IN[1] = '0;
      model_reset();
      repeat (2) @(negedge CLK);
      check("reset_segment", 64'(SEGMENT), 64'd0);
      check("reset_idx", 64'(IDX), 64'd0);
      check("reset_stop", 64'(STOP), 64'd0);
      RST = 1'b0;

      // Segment 0 ramp: IDX lags IDX_IN[0] by one cycle.
      for (int k = 0; k < 12; k++) begin
         v = IDX_IN[0];
         step();
         check("track0", 64'(IDX), 64'(v));
      end

      // SYNC_IDX switch to segment 1 requested while IDX_IN[1] sits at 5.
      n = 0;
      while (IDX_IN[1] != 15'd5 && n < 20) begin step(); n++; end
      strobe(1'b1, 16'hFFFF, 3'd0, 64'd0);
      step();
      step();
      check("sync_hold", 64'(SEGMENT), 64'd0);
      step();
      check("sync_switch", 64'(SEGMENT), 64'd1);
      check("sync_idx", 64'(IDX), 64'd0);

      // Finite playback REP=2 on a 4-long cycle, then hold.
      CYCLE[1] = 15'd3; IDX_IN[1] = '0;
      step();
      strobe(1'b1, 16'd2, 3'd7, 64'd0);
      n = 0;
      while (STOP !== 1'b1 && n < 40) begin step(); n++; end
      check("rep2_stop", 64'(STOP), 64'd1);
      check("rep2_idx", 64'(IDX), 64'd3);
      check("rep2_segment", 64'(SEGMENT), 64'd1);
      for (int k = 0; k < 20; k++) begin
         step();
         check("done_hold_idx", 64'(IDX), 64'd3);
         check("done_hold_stop", 64'(STOP), 64'd1);
      end

      // SYS_TIME trigger in the future, then one already in the past.
      SYS_TIME = 64'd990;
      strobe(1'b0, 16'hFFFF, 3'd1, 64'd1000);
      n = 0;
      while (SYS_TIME != 64'd1000 && n < 20) begin
         step();
         check("systime_wait", 64'(SEGMENT), 64'd1);
         n++;
      end
      step();
      check("systime_switch", 64'(SEGMENT), 64'd0);
      check("systime_stop", 64'(STOP), 64'd0);
      strobe(1'b1, 16'hFFFF, 3'd1, 64'd500);
      check("systime_past_hold", 64'(SEGMENT), 64'd0);
      step();
      check("systime_past", 64'(SEGMENT), 64'd1);

      // GPIO trigger: a level already high must not fire, a fresh rising edge must.
      GPIO_IN = 4'b0100;
      step(); step();
      strobe(1'b0, 16'hFFFF, 3'd2, {32'($urandom), 30'($urandom), 2'd2});
      for (int k = 0; k < 5; k++) begin
         GPIO_IN = 4'($urandom) | 4'b0100;
         step();
         check("gpio_level", 64'(SEGMENT), 64'd1);
      end
      GPIO_IN[2] = 1'b0;
      step();
      check("gpio_low", 64'(SEGMENT), 64'd1);
      GPIO_IN[2] = 1'b1;
      step();
      check("gpio_rise", 64'(SEGMENT), 64'd0);

      // A second strobe replaces a pending far-future SYS_TIME request.
      strobe(1'b1, 16'hFFFF, 3'd1, 64'd1000000);
      repeat (3) step();
      strobe(1'b0, 16'hFFFF, 3'd7, 64'd0);
      SYS_TIME = 64'd2000000;
      repeat (5) step();
      check("override", 64'(SEGMENT), 64'd0);

      // Reset during finite playback returns to idle immediately and drops the request.
      CYCLE[1] = 15'd7; IDX_IN[1] = '0;
      strobe(1'b1, 16'd5, 3'd7, 64'd0);
      repeat (4) step();
      RST = 1'b1;
      #1;
      check("rst_mid_segment", 64'(SEGMENT), 64'd0);
      check("rst_mid_idx", 64'(IDX), 64'd0);
      check("rst_mid_stop", 64'(STOP), 64'd0);
      model_reset();
      @(negedge CLK);
      RST = 1'b0;
      repeat (10) step();
      check("rst_no_pending", 64'(SEGMENT), 64'd0);

      // Random soak: strobes of every mode (including undefined codes) against the model.
      CYCLE[0] = 15'($urandom_range(1, 6));
      CYCLE[1] = 15'($urandom_range(1, 6));
      IDX_IN[0] = '0; IDX_IN[1] = '0;
      for (int k = 0; k < 400; k++) begin
         logic [2:0]  mode;
         logic [15:0] rep;
         logic [63:0] val;
         GPIO_IN = 4'($urandom);
         if ($urandom_range(0, 11) == 0) begin
            mode = 3'($urandom);
            rep  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
            val  = (mode == 3'd1) ? SYS_TIME + 64'($urandom_range(0, 20)) : {32'($urandom), 32'($urandom)};
            strobe(1'($urandom_range(0, 1)), rep, mode, val);
         end else begin
            step();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/modulation_swapchain.md
Name: modulation_swapchain

Overview:
- Consumer side of the modulation timer interface. Takes the per-segment modulation indices and the settings-update strobe from the timer.
- Selects which segment currently drives the modulation buffer read. Handles segment transitions on configurable trigger conditions and finite repeat counts.
- Emits the active segment, the read index and a stop flag to the modulation memory reader.

Parameters:
- NumSegment, 2 (from params package), number of modulation segments.
- IdxWidth, 15, width of modulation index and cycle fields.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- SYS_TIME  in  64  synchronised system time.
- UPDATE_SETTINGS  in  1  one-cycle strobe from the timer: new request and divider settings are valid.
- REQ_SEGMENT  in  1  segment requested to become active.
- REP  in  16  repeat count for the requested segment. Segment plays REP+1 cycles; 16'hFFFF means infinite.
- TRANSITION_MODE  in  3  trigger kind, type transition_mode_t.
- TRANSITION_VALUE  in  64  trigger argument (system time or GPIO number).
- GPIO_IN  in  4  external trigger inputs, already synchronised.
- CYCLE[NumSegment]  in  15 each  last valid index per segment (cycle length − 1).
- IDX_IN[NumSegment]  in  15 each  free-running indices from the timer.
- SEGMENT  out  1  active segment.
- IDX  out  15  read index for the active segment.
- STOP  out  1  finite playback finished.

Behaviour:
- Reset (asynchronous): SEGMENT=0, IDX=0, STOP=0, state=INFINITE_LOOP, latched request cleared (req_segment=0, rep=FFFF, mode=SYNC_IDX).
- Request latch: on UPDATE_SETTINGS, latch REQ_SEGMENT, REP, TRANSITION_MODE, TRANSITION_VALUE.
  - If REQ_SEGMENT equals SEGMENT and REP=FFFF: state→INFINITE_LOOP, STOP cleared.
  - Otherwise: state→WAIT_START.
  - A new strobe in any state, including WAIT_START, overwrites the pending request.
- Wrap detection: per segment, register the previous IDX_IN. wrap[i] = IDX_IN[i] < prev[i].
- States:
  - INFINITE_LOOP: IDX follows IDX_IN[SEGMENT]; STOP=0.
  - WAIT_START: outputs still follow the old segment; waits for the trigger of the latched mode:
    - IMMEDIATE: fires on the cycle after the latch.
    - SYNC_IDX: fires on wrap[req_segment].
    - SYS_TIME: fires when SYS_TIME ≥ TRANSITION_VALUE, unsigned 64-bit compare. A time already in the past fires on the first cycle.
    - GPIO: fires on a rising edge of GPIO_IN[TRANSITION_VALUE[1:0]]. A level already high does not fire.
    - Undefined codes: behave as IMMEDIATE.
  - On trigger: SEGMENT←req_segment, STOP←0, loop_cnt←0. Next state is INFINITE_LOOP if REP=FFFF, else FINITE_LOOP.
  - FINITE_LOOP: IDX follows IDX_IN[SEGMENT].
    - Each wrap[SEGMENT] increments loop_cnt (16 bit).
    - On the wrap where loop_cnt==REP: STOP←1, IDX←CYCLE[SEGMENT] (held), state→DONE.
    - REP=0 therefore plays exactly one full wrap-to-wrap cycle.
  - DONE: IDX and SEGMENT held, STOP=1, until the next UPDATE_SETTINGS.
- Output latency: IDX is registered, IDX(t+1) = IDX_IN[SEGMENT](t). SEGMENT and STOP change on the same edge as the corresponding IDX value.
- Simultaneous events:
  - UPDATE_SETTINGS in the same cycle as a trigger or final wrap: the strobe wins. The old trigger or wrap is discarded and the new request is latched.
  - The trigger cycle itself never counts as a loop wrap.
- Reset asserted mid-playback: immediate return to the reset values. No pending request survives.

Decomposition:
- params package:
  - transition_mode_t enum, 3 bits: SYNC_IDX=0, SYS_TIME=1, GPIO=2, IMMEDIATE=7.
  - swapchain state_t enum: INFINITE_LOOP, WAIT_START, FINITE_LOOP, DONE.
  - constant RepInfinite = 16'hFFFF.
- One natural sub-module: transition_trigger. Combines the mode decode, SYS_TIME compare and GPIO edge detect into a single-cycle fire pulse.
- Wrap detection and the state machine stay in the top module.

Test Plan:
- Reset, then IDX_IN[0] ramping 0..9 with CYCLE[0]=9 → SEGMENT=0, STOP=0, IDX tracks IDX_IN[0] with 1-cycle latency.
- Strobe REQ_SEGMENT=1, REP=FFFF, mode=SYNC_IDX while IDX_IN[1] is at 5 of 0..7 → SEGMENT switches on the cycle after IDX_IN[1] returns to 0; IDX=0 follows.
- Strobe REQ_SEGMENT=1, REP=2, mode=IMMEDIATE, CYCLE[1]=3 → after the 3rd wrap of IDX_IN[1]: STOP=1, IDX held at 3; a further 20 cycles of IDX_IN show no change.
- mode=SYS_TIME, TRANSITION_VALUE=1000, SYS_TIME counting from 990 → SEGMENT changes in the cycle after SYS_TIME=1000. Repeat with value 500 → changes 1 cycle after the strobe.
- mode=GPIO, value=2, GPIO_IN[2] held high before the strobe → no switch. Drive low then high → switch after the rising edge.
- Second strobe (REQ_SEGMENT=0, IMMEDIATE) during WAIT_START for SYS_TIME=10^6 → segment 0 stays selected and the SYS_TIME trigger is ignored. Also assert RST during FINITE_LOOP → SEGMENT=0, IDX=0, STOP=0 immediately.
